// File: rtl/kernel_launcher_pkg.sv
// Shared types and widths for the kernel launcher and its divider.
package kernel_launcher_pkg;
  localparam int MAX_WG_SIZE_DEF = 256;
  localparam int GS_W            = 32;
  localparam int LS_W            = 9;
  localparam int CNT_W           = 64;
  localparam int WG_PROD_W       = 27;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_DIVIDE, ST_PRODUCT, ST_RUN, ST_CLEAN, ST_DONE
  } kl_state_e;
endpackage

// File: rtl/kernel_launcher_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle; the final
// step's result is presented combinationally alongside o_done.
module seq_divider
  import kernel_launcher_pkg::*;
#(
  parameter int DIV_STEPS = 32
)(
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_start,
  input  logic [GS_W-1:0] i_dividend,
  input  logic [LS_W-1:0] i_divisor,
  output logic            o_done,
  output logic [GS_W-1:0] o_quotient,
  output logic [LS_W-1:0] o_remainder
);
  localparam int CW = $clog2(DIV_STEPS + 1);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [GS_W-1:0] r_quo;
  logic [LS_W-1:0] r_rem;
  logic [LS_W-1:0] r_div;

  logic [GS_W-1:0] w_quo_in;
  logic [LS_W-1:0] w_rem_in;
  logic [LS_W-1:0] w_div_in;
  logic [LS_W:0]   w_trial;
  logic            w_fits;
  logic [GS_W-1:0] w_quo_nxt;
  logic [LS_W-1:0] w_rem_nxt;

  // The start cycle already performs the first step on the raw operands.
  always_comb begin
    w_quo_in  = i_start ? i_dividend : r_quo;
    w_rem_in  = i_start ? '0 : r_rem;
    w_div_in  = i_start ? i_divisor : r_div;
    w_trial   = {w_rem_in, w_quo_in[GS_W-1]};
    w_fits    = (w_trial >= {1'b0, w_div_in});
    w_rem_nxt = w_fits ? LS_W'(w_trial - {1'b0, w_div_in}) : w_trial[LS_W-1:0];
    w_quo_nxt = {w_quo_in[GS_W-2:0], w_fits};
  end

  assign o_done      = r_busy && (r_cnt == CW'(DIV_STEPS - 1));
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(1);
      r_quo  <= w_quo_nxt;
      r_rem  <= w_rem_nxt;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      r_cnt  <= r_cnt + 1'b1;
      r_quo  <= w_quo_nxt;
      r_rem  <= w_rem_nxt;
      if (o_done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/kernel_launcher.sv
// Launch sequencer: validates an NDRange command, derives group counts and
// totals, runs the kernel and performs the cleanup handshake.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int MAX_WG_SIZE = MAX_WG_SIZE_DEF,
  parameter int DIV_STEPS   = 32
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_select,
  input  logic [GS_W-1:0]  cmd_global_size_0,
  input  logic [GS_W-1:0]  cmd_global_size_1,
  input  logic [GS_W-1:0]  cmd_global_size_2,
  input  logic [LS_W-1:0]  cmd_local_size_0,
  input  logic [LS_W-1:0]  cmd_local_size_1,
  input  logic [LS_W-1:0]  cmd_local_size_2,
  output logic [7:0]       opencl_select,
  output logic             opencl_on,
  output logic             opencl_clean,
  input  logic             opencl_complete,
  input  logic             opencl_cleaned,
  output logic [GS_W-1:0]  opencl_global_size_0,
  output logic [GS_W-1:0]  opencl_global_size_1,
  output logic [GS_W-1:0]  opencl_global_size_2,
  output logic [LS_W-1:0]  opencl_local_size_0,
  output logic [LS_W-1:0]  opencl_local_size_1,
  output logic [LS_W-1:0]  opencl_local_size_2,
  output logic [GS_W-1:0]  opencl_num_groups_0,
  output logic [GS_W-1:0]  opencl_num_groups_1,
  output logic [GS_W-1:0]  opencl_num_groups_2,
  output logic [CNT_W-1:0] opencl_num_work_items,
  output logic [CNT_W-1:0] opencl_num_work_groups,
  output logic [LS_W-1:0]  opencl_work_group_size,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] run_cycles
);
  kl_state_e        r_state;
  logic [GS_W-1:0]  r_gs [3];
  logic [LS_W-1:0]  r_ls [3];
  logic [GS_W-1:0]  r_ng [3];
  logic [7:0]       r_sel;
  logic [CNT_W-1:0] r_items, r_groups, r_run_cnt;
  logic [LS_W-1:0]  r_wgs;
  logic             r_ready, r_busy, r_done, r_err, r_on, r_clean;
  logic [1:0]       r_dim;
  logic             r_div_start;

  logic [WG_PROD_W-1:0] w_wg_prod;
  logic                 w_reject;
  logic                 w_div_done;
  logic [GS_W-1:0]      w_quo;
  logic [LS_W-1:0]      w_rem;

  // Wide enough that 511^3 cannot wrap past the limit.
  assign w_wg_prod = WG_PROD_W'(r_ls[0]) * WG_PROD_W'(r_ls[1]) * WG_PROD_W'(r_ls[2]);
  assign w_reject  = (r_gs[0] == '0) || (r_gs[1] == '0) || (r_gs[2] == '0) ||
                     (r_ls[0] == '0) || (r_ls[1] == '0) || (r_ls[2] == '0) ||
                     (w_wg_prod > WG_PROD_W'(MAX_WG_SIZE));

  seq_divider #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk         (clk),
    .rstn        (rstn),
    .i_start     (r_div_start),
    .i_dividend  (r_gs[r_dim]),
    .i_divisor   (r_ls[r_dim]),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < 3; i++) begin
        r_gs[i] <= '0;
        r_ls[i] <= '0;
        r_ng[i] <= '0;
      end
      r_sel       <= '0;
      r_items     <= '0;
      r_groups    <= '0;
      r_run_cnt   <= '0;
      r_wgs       <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_on        <= 1'b0;
      r_clean     <= 1'b0;
      r_dim       <= '0;
      r_div_start <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_ready && cmd_valid) begin
            r_sel    <= cmd_select;
            r_gs[0]  <= cmd_global_size_0;
            r_gs[1]  <= cmd_global_size_1;
            r_gs[2]  <= cmd_global_size_2;
            r_ls[0]  <= cmd_local_size_0;
            r_ls[1]  <= cmd_local_size_1;
            r_ls[2]  <= cmd_local_size_2;
            for (int i = 0; i < 3; i++) r_ng[i] <= '0;
            r_items  <= '0;
            r_groups <= '0;
            r_wgs    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_CHECK;
          end else begin
            r_ready  <= 1'b1;
          end
        end
        ST_CHECK: begin
          r_wgs <= w_wg_prod[LS_W-1:0];
          if (w_reject) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_dim       <= '0;
            r_div_start <= 1'b1;
            r_state     <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            r_ng[r_dim] <= w_quo;
            if (w_rem != '0) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else if (r_dim == 2'd2) begin
              r_state <= ST_PRODUCT;
            end else begin
              r_dim       <= r_dim + 2'd1;
              r_div_start <= 1'b1;
            end
          end
        end
        ST_PRODUCT: begin
          r_items   <= CNT_W'(r_gs[0]) * CNT_W'(r_gs[1]) * CNT_W'(r_gs[2]);
          r_groups  <= CNT_W'(r_ng[0]) * CNT_W'(r_ng[1]) * CNT_W'(r_ng[2]);
          r_run_cnt <= '0;
          r_on      <= 1'b1;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          if (opencl_complete) begin
            r_on    <= 1'b0;
            r_clean <= 1'b1;
            r_state <= ST_CLEAN;
          end
        end
        ST_CLEAN: begin
          if (opencl_cleaned) begin
            r_clean <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready              = r_ready;
  assign opencl_select          = r_sel;
  assign opencl_on              = r_on;
  assign opencl_clean           = r_clean;
  assign opencl_global_size_0   = r_gs[0];
  assign opencl_global_size_1   = r_gs[1];
  assign opencl_global_size_2   = r_gs[2];
  assign opencl_local_size_0    = r_ls[0];
  assign opencl_local_size_1    = r_ls[1];
  assign opencl_local_size_2    = r_ls[2];
  assign opencl_num_groups_0    = r_ng[0];
  assign opencl_num_groups_1    = r_ng[1];
  assign opencl_num_groups_2    = r_ng[2];
  assign opencl_num_work_items  = r_items;
  assign opencl_num_work_groups = r_groups;
  assign opencl_work_group_size = r_wgs;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign error                  = r_err;
  assign run_cycles             = r_run_cnt;
endmodule

// File: tb/tb_kernel_launcher.sv
// Scoreboard bench for kernel_launcher with a reactive kernel model.
module tb_kernel_launcher;
  localparam int MAXWG = 256;

  logic        clk, rstn;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_select;
  logic [31:0] cmd_global_size_0, cmd_global_size_1, cmd_global_size_2;
  logic [8:0]  cmd_local_size_0, cmd_local_size_1, cmd_local_size_2;
  logic [7:0]  opencl_select;
  logic        opencl_on, opencl_clean, opencl_complete, opencl_cleaned;
  logic [31:0] opencl_global_size_0, opencl_global_size_1, opencl_global_size_2;
  logic [8:0]  opencl_local_size_0, opencl_local_size_1, opencl_local_size_2;
  logic [31:0] opencl_num_groups_0, opencl_num_groups_1, opencl_num_groups_2;
  logic [63:0] opencl_num_work_items, opencl_num_work_groups;
  logic [8:0]  opencl_work_group_size;
  logic        busy, done, error;
  logic [63:0] run_cycles;

  kernel_launcher #(.MAX_WG_SIZE(MAXWG), .DIV_STEPS(32)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_select(cmd_select),
    .cmd_global_size_0(cmd_global_size_0), .cmd_global_size_1(cmd_global_size_1),
    .cmd_global_size_2(cmd_global_size_2),
    .cmd_local_size_0(cmd_local_size_0), .cmd_local_size_1(cmd_local_size_1),
    .cmd_local_size_2(cmd_local_size_2),
    .opencl_select(opencl_select), .opencl_on(opencl_on), .opencl_clean(opencl_clean),
    .opencl_complete(opencl_complete), .opencl_cleaned(opencl_cleaned),
    .opencl_global_size_0(opencl_global_size_0), .opencl_global_size_1(opencl_global_size_1),
    .opencl_global_size_2(opencl_global_size_2),
    .opencl_local_size_0(opencl_local_size_0), .opencl_local_size_1(opencl_local_size_1),
    .opencl_local_size_2(opencl_local_size_2),
    .opencl_num_groups_0(opencl_num_groups_0), .opencl_num_groups_1(opencl_num_groups_1),
    .opencl_num_groups_2(opencl_num_groups_2),
    .opencl_num_work_items(opencl_num_work_items), .opencl_num_work_groups(opencl_num_work_groups),
    .opencl_work_group_size(opencl_work_group_size),
    .busy(busy), .done(done), .error(error), .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       sel;
    logic [2:0][31:0] g;
    logic [2:0][8:0]  l;
    logic [15:0]      d;
  } cmd_t;

  typedef struct packed {
    logic             err;
    logic [7:0]       sel;
    logic [2:0][31:0] g;
    logic [2:0][8:0]  l;
    logic [2:0][31:0] ng;
    logic [63:0]      wi;
    logic [63:0]      wg;
    logic [8:0]       wgs;
    logic [63:0]      rc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] d_arr [256];
  int          n_runs = 0;
  int          tests = 0;
  int          fails = 0;
  int          viol_oc = 0;
  int          viol_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, want);
    end
  endtask

  // Reference behaviour derived directly from the launch rules.
  function automatic exp_t ref_model(input cmd_t c);
    exp_t e;
    logic [63:0] p;
    e = '0;
    e.sel = c.sel;
    e.g = c.g;
    e.l = c.l;
    p = 64'(c.l[0]) * 64'(c.l[1]) * 64'(c.l[2]);
    e.wgs = p[8:0];
    e.err = (p == 0) || (p > MAXWG) || (c.g[0] == 0) || (c.g[1] == 0) || (c.g[2] == 0);
    for (int i = 0; i < 3; i++) begin
      if (c.l[i] != 0) begin
        e.ng[i] = c.g[i] / 32'(c.l[i]);
        if (c.g[i] % 32'(c.l[i]) != 0) e.err = 1'b1;
      end
    end
    e.wi = 64'(c.g[0]) * 64'(c.g[1]) * 64'(c.g[2]);
    e.wg = 64'(e.ng[0]) * 64'(e.ng[1]) * 64'(e.ng[2]);
    e.rc = 64'(c.d) + 64'd1;
    return e;
  endfunction

  task automatic issue(input cmd_t c, input bit push);
    exp_t e;
    int b;
    e = ref_model(c);
    cmd_valid = 1'b1;
    cmd_select = c.sel;
    cmd_global_size_0 = c.g[0];
    cmd_global_size_1 = c.g[1];
    cmd_global_size_2 = c.g[2];
    cmd_local_size_0 = c.l[0];
    cmd_local_size_1 = c.l[1];
    cmd_local_size_2 = c.l[2];
    b = 0;
    while (!cmd_ready && b < 5000) begin
      @(negedge clk);
      b++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!e.err) begin
      d_arr[n_runs[7:0]] = c.d;
      n_runs++;
    end
    if (push) exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  function automatic cmd_t mk(input logic [7:0] s, input logic [31:0] g0, g1, g2,
                              input logic [8:0] l0, l1, l2, input logic [15:0] d);
    cmd_t c;
    c.sel = s;
    c.g[0] = g0; c.g[1] = g1; c.g[2] = g2;
    c.l[0] = l0; c.l[1] = l1; c.l[2] = l2;
    c.d = d;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int k;
    c.sel = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      c.l[i] = 9'($urandom_range(1, 8));
      c.g[i] = 32'(c.l[i]) * 32'($urandom_range(1, 20));
    end
    k = $urandom_range(0, 2);
    case ($urandom_range(0, 5))
      0: c.g[k] = c.g[k] + 32'd1;
      1: c.l[0] = 9'($urandom_range(9, 300));
      2: c.g[k] = '0;
      default: ;
    endcase
    c.d = 16'($urandom_range(0, 15));
    return c;
  endfunction

  // Kernel model: raises complete d RUN cycles in, acknowledges cleanup after a random delay.
  initial begin
    int k, cur_d, cln, cdel, r_idx;
    bit in_run;
    k = 0; cur_d = 0; cln = 0; cdel = 0; r_idx = 0; in_run = 0;
    opencl_complete = 1'b0;
    opencl_cleaned = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in_run = 0; cln = 0;
        opencl_complete = 1'b0;
        opencl_cleaned = 1'b0;
      end else if (opencl_on) begin
        if (!in_run) begin
          in_run = 1; k = 0;
          cur_d = (r_idx < n_runs) ? int'(d_arr[r_idx[7:0]]) : 0;
          r_idx++;
        end
        if (k >= cur_d) opencl_complete = 1'b1;
        k++;
      end else if (opencl_clean) begin
        opencl_complete = 1'b0;
        in_run = 0;
        if (cln == 0) cdel = $urandom_range(0, 3);
        if (cln >= cdel) opencl_cleaned = 1'b1;
        cln++;
      end else begin
        opencl_cleaned = 1'b0;
        cln = 0;
        if (busy && r_idx < n_runs && d_arr[r_idx[7:0]] == 16'd0) opencl_complete = 1'b1;
      end
    end
  end

  // Monitor: one expected record is retired per done pulse.
  initial begin
    exp_t e;
    bit on_seen;
    on_seen = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        on_seen = 0;
      end else begin
        if (opencl_on && opencl_clean) viol_oc++;
        if (busy && cmd_ready) viol_rdy++;
        if (opencl_on) on_seen = 1;
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("error", 64'(error), 64'(e.err));
            chk("on_pulse", 64'(on_seen), 64'(!e.err));
            chk("select", 64'(opencl_select), 64'(e.sel));
            chk("g0", 64'(opencl_global_size_0), 64'(e.g[0]));
            chk("g2", 64'(opencl_global_size_2), 64'(e.g[2]));
            chk("l1", 64'(opencl_local_size_1), 64'(e.l[1]));
            chk("wg_size", 64'(opencl_work_group_size), 64'(e.wgs));
            if (!e.err) begin
              chk("ngroups0", 64'(opencl_num_groups_0), 64'(e.ng[0]));
              chk("ngroups1", 64'(opencl_num_groups_1), 64'(e.ng[1]));
              chk("ngroups2", 64'(opencl_num_groups_2), 64'(e.ng[2]));
              chk("work_items", opencl_num_work_items, e.wi);
              chk("work_groups", opencl_num_work_groups, e.wg);
              chk("run_cycles", run_cycles, e.rc);
            end
          end
          on_seen = 0;
        end
      end
    end
  end

  initial begin
    int b;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_select = '0;
    cmd_global_size_0 = '0; cmd_global_size_1 = '0; cmd_global_size_2 = '0;
    cmd_local_size_0 = '0; cmd_local_size_1 = '0; cmd_local_size_2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_on", 64'(opencl_on), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_run_cycles", run_cycles, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Abort a running kernel with an asynchronous reset.
    issue(mk(8'h5a, 32'd4, 32'd1, 32'd1, 9'd2, 9'd1, 9'd1, 16'd60), 1'b0);
    b = 0;
    while (!opencl_on && b < 400) begin
      @(negedge clk);
      b++;
    end
    chk("midrun_on_seen", 64'(opencl_on), 64'd1);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrun_rst_on", 64'(opencl_on), 64'd0);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_sel", 64'(opencl_select), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrun_ready_after", 64'(cmd_ready), 64'd1);

    // Directed cases, issued back to back so later commands are held while busy.
    issue(mk(8'h01, 32'd1024, 32'd8, 32'd1, 9'd64, 9'd8, 9'd1, 16'd3), 1'b1);
    issue(mk(8'h02, 32'd1024, 32'd8, 32'd1, 9'd32, 9'd8, 9'd1, 16'd10), 1'b1);
    issue(mk(8'h03, 32'd100, 32'd1, 32'd1, 9'd7, 9'd1, 9'd1, 16'd2), 1'b1);
    issue(mk(8'h04, 32'd12, 32'd6, 32'd4, 9'd3, 9'd2, 9'd4, 16'd0), 1'b1);
    issue(mk(8'h05, 32'd0, 32'd4, 32'd4, 9'd1, 9'd2, 9'd2, 16'd1), 1'b1);
    issue(mk(8'h06, 32'd8, 32'd8, 32'd9, 9'd2, 9'd2, 9'd2, 16'd1), 1'b1);
    issue(mk(8'h07, 32'hFFFF_FFFF, 32'd3, 32'd5, 9'd1, 9'd3, 9'd5, 16'd4), 1'b1);
    issue(mk(8'h08, 32'd16, 32'd16, 32'd1, 9'd16, 9'd16, 9'd1, 16'd0), 1'b1);
    for (int n = 0; n < 20; n++) issue(rand_cmd(), 1'b1);

    b = 0;
    while (exp_q.size() != 0 && b < 20000) begin
      @(negedge clk);
      b++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("on_clean_overlap", 64'(viol_oc), 64'd0);
    chk("ready_while_busy", 64'(viol_rdy), 64'd0);
    repeat (4) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/kernel_launcher.md
KERNEL_LAUNCHER -- requirements
Module: kernel_launcher

Interface
REQ-001 Parameter MAX_WG_SIZE, default 256, maximum legal work-group size (l0*l1*l2).
REQ-002 Parameter DIV_STEPS, default 32, number of iterations per divide (equals the global-size width).
REQ-003 clk  in  1  sole clock; all logic is on the rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  host launch-command handshake.
REQ-006 cmd_select  in  8  kernel index.
REQ-007 cmd_global_size_0..2  in  32 each  NDRange global sizes.
REQ-008 cmd_local_size_0..2  in  9 each  work-group local sizes.
REQ-009 opencl_select  out  8  registered copy of cmd_select.
REQ-010 opencl_on  out  1  kernel run request.
REQ-011 opencl_clean  out  1  kernel cleanup request.
REQ-012 opencl_complete / opencl_cleaned  in / in  1 / 1  level acknowledgements from the kernel.
REQ-013 opencl_global_size_0..2 / opencl_local_size_0..2  out  32 / 9 each  latched sizes.
REQ-014 opencl_num_groups_0..2  out  32 each  global_size_i / local_size_i.
REQ-015 opencl_num_work_items / opencl_num_work_groups  out  64 / 64  products of the sizes and of the group counts respectively.
REQ-016 opencl_work_group_size  out  9  l0*l1*l2.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 error  out  1  valid with done; set when the command was rejected.
REQ-020 run_cycles  out  64  cycle count of the last RUN phase; valid with done.

Function
REQ-021 FSM states: IDLE, CHECK, DIVIDE, PRODUCT, RUN, CLEAN, DONE.
REQ-022 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch all cmd_* fields into the opencl_* size/select registers and go to CHECK.
REQ-023 cmd_ready is 0 in every state other than IDLE; commands presented then are not accepted.
REQ-024 CHECK (1 cycle): any global size 0, any local size 0, or l0*l1*l2 > MAX_WG_SIZE -> DONE with error=1; otherwise go to DIVIDE.
REQ-025 The work-group-size product is computed at ≥27-bit width before comparison; opencl_work_group_size holds its low 9 bits.
REQ-026 DIVIDE: restoring shift-subtract division, one quotient bit per cycle, DIV_STEPS cycles per dimension, dimensions 0 then 1 then 2 (3*DIV_STEPS cycles total).
REQ-027 A nonzero remainder in any dimension -> DONE with error=1 immediately after that dimension; the remaining dimensions are not divided.
REQ-028 PRODUCT (1 cycle): num_work_items = g0*g1*g2 and num_work_groups = n0*n1*n2, each truncated to 64 bits; then go to RUN.
REQ-029 RUN: opencl_on=1; run_cycles counter clears on RUN entry and increments each RUN cycle.
REQ-030 In RUN, the first cycle with opencl_complete=1 drops opencl_on the next cycle and moves to CLEAN; that cycle is included in the count.
REQ-031 opencl_complete asserted on the RUN entry cycle is honoured, giving run_cycles=1.
REQ-032 CLEAN: opencl_clean=1 until opencl_cleaned=1 is observed, then go to DONE; opencl_on and opencl_clean are never high together.
REQ-033 DONE (1 cycle): done=1, error valid; next state is IDLE.
REQ-034 All opencl_* size/count outputs hold from acceptance until the next acceptance.
REQ-035 No timeout: RUN and CLEAN wait indefinitely.

Reset
REQ-036 rstn low asynchronously forces IDLE and clears every output and register to 0, including opencl_on and opencl_clean, regardless of state (mid-RUN included).
REQ-037 cmd_ready rises in the first cycle after rstn deasserts.

Structure
REQ-038 The FSM state enum, MAX_WG_SIZE default and size widths (32, 9, 64) reside in the shared package kernel_launcher_pkg.
REQ-039 The divider is a sub-module, seq_divider (32-bit dividend, 9-bit divisor, start/done handshake), reused for all three dimensions.

Verification
REQ-040 Case g=(1024,8,1), l=(64,8,1) -> num_groups=(16,1,1), work_group_size=512 exceeds 256 -> done with error=1 and no opencl_on pulse; with l=(32,8,1) -> groups (32,1,1), wg_size 256, work_items 8192, work_groups 32, done with error=0.
REQ-041 Case g=(100,1,1), l=(7,1,1) -> error=1 after dimension-0 divide; opencl_on never asserted.
REQ-042 Case: kernel model asserts complete 10 cycles after opencl_on -> run_cycles=11, then clean handshake, then a single done pulse.
REQ-043 Case: cmd_valid held during RUN -> cmd_ready=0 and no second launch; accepted on return to IDLE.
REQ-044 Case: rstn pulsed low mid-RUN -> opencl_on=0 asynchronously, busy=0, cmd_ready=1 the cycle after release.
REQ-045 Case: complete already high on the RUN entry cycle -> run_cycles=1.
